// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants and frame check for the PS/2 keyboard buffer
package kbd_pkg;

    localparam int FIFO_DEPTH_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 50000;
    localparam int FRAME_BITS      = 11;
    localparam int READY_BIT       = 8;
    localparam int OVF_BIT         = 9;
    localparam int KEY_W           = 32;

    typedef logic [7:0] scan_code_t;

    // sr holds {parity, d7..d0, start} after ten shifts; stop is the eleventh bit.
    function automatic logic frame_ok(input logic [9:0] sr, input logic stop);
        return (sr[0] == 1'b0) && stop && (^sr[9:1]);
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - synchronous scan-code FIFO with push/pop and combinational head
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot, so a push into a full FIFO is still taken when paired with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_buffer.sv
// rtl/ps2_kbd_buffer.sv - PS/2 frame receiver feeding a CPU-readable scan-code FIFO
module ps2_kbd_buffer
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              read_key,
    output logic [KEY_W-1:0]  key_data,
    output logic              ready,
    output logic              overflow
);

    localparam int              IDLE_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
    localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 1);

    logic [2:0]        clk_sync;
    logic [2:0]        data_sync;
    logic              fall;
    logic [9:0]        shift_reg;
    logic [3:0]        bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              push_pend;
    scan_code_t        push_byte;
    logic              read_key_q;
    logic              pop_edge;
    logic              full;
    logic              empty;
    scan_code_t        head;
    logic              drop;
    logic              overflow_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign fall = (clk_sync[2:1] == 2'b10);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            push_pend <= 1'b0;
            push_byte <= '0;
        end else begin
            push_pend <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                    push_pend <= frame_ok(shift_reg, data_sync[2]);
                    push_byte <= shift_reg[8:1];
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= {data_sync[2], shift_reg[9:1]};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
            end else begin
                if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
                // A keyboard that stops mid-frame must not corrupt the next one.
                if ((bit_cnt != 4'd0) && (idle_cnt == IDLE_MAX)) begin
                    bit_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            read_key_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            read_key_q <= read_key;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (pop_edge) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign pop_edge = read_key & ~read_key_q;
    assign drop     = push_pend & full & ~pop_edge;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push_pend),
        .push_data (push_byte),
        .pop       (pop_edge),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign ready    = ~empty;
    assign overflow = overflow_q;

    always_comb begin
        key_data            = '0;
        key_data[7:0]       = head;
        key_data[READY_BIT] = ready;
        key_data[OVF_BIT]   = overflow_q;
    end

endmodule

// File: tb/tb_ps2_kbd_buffer.sv
// tb/tb_ps2_kbd_buffer.sv - self-checking bench for ps2_kbd_buffer
module tb_ps2_kbd_buffer;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 10;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        read_key = 1'b0;
    logic [31:0] key_data;
    logic        ready;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;
    bit settled    = 1'b0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;

    ps2_kbd_buffer #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .read_key (read_key),
        .key_data (key_data),
        .ready    (ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word();
        logic [7:0] h;
        h = (mq.size() != 0) ? mq[0] : 8'h00;
        return {22'b0, m_ovf, (mq.size() != 0), h};
    endfunction

    always @(negedge clk) begin
        if (settled) begin
            compared++;
            if (key_data !== model_word() || ready !== (mq.size() != 0) || overflow !== m_ovf) begin
                mismatched++;
                $display("FAIL model_cmp t=%0t key_data=%h ready=%b overflow=%b expected key_data=%h",
                         $time, key_data, ready, overflow, model_word());
            end
        end
    end

    task automatic check_kd(input string name, input logic [31:0] exp);
        compared++;
        if (key_data !== exp) begin
            mismatched++;
            $display("FAIL %s: key_data=%h expected %h", name, key_data, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                               input bit bad_start, input bit bad_stop);
        logic [10:0] f;
        f[0]   = bad_start;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = ~bad_stop;
        return f;
    endfunction

    task automatic ps2_bit(input logic v, input bit last);
        @(negedge clk);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (last) settled = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_start, input bit bad_stop);
        logic [10:0] f;
        f = frame_bits(b, bad_par, bad_start, bad_stop);
        for (int i = 0; i < 11; i++) ps2_bit(f[i], i == 10);
        repeat (6) @(negedge clk);
        if (!bad_par && !bad_start && !bad_stop) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(b);
        end
        settled = 1'b1;
    endtask

    task automatic read_pulse(input int hold);
        @(negedge clk);
        read_key = 1'b1;
        settled  = 1'b0;
        @(posedge clk);
        #1;
        m_ovf = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        settled = 1'b1;
        repeat (hold) @(negedge clk);
        read_key = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        settled  = 1'b0;
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        check_kd("reset_state", 32'h0000_0000);
        clrn = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        settled = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_kd("after_reset", 32'h0000_0000);

        send_frame(8'h1C, 0, 0, 0);
        check_kd("good_1c", 32'h0000_011C);
        read_pulse(1);
        check_kd("good_1c_read", 32'h0000_0000);

        send_frame(8'h1C, 1, 0, 0);
        check_kd("bad_parity", 32'h0000_0000);
        send_frame(8'h33, 0, 1, 0);
        check_kd("bad_start", 32'h0000_0000);
        send_frame(8'h33, 0, 0, 1);
        check_kd("bad_stop", 32'h0000_0000);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
        check_kd("overflow_word", 32'h0000_0301);
        for (int i = 0; i < 8; i++) begin
            check_kd("overflow_drain", (i == 0) ? 32'h0000_0301 : (32'h0000_0100 | 32'(i + 1)));
            read_pulse(2);
        end
        check_kd("overflow_empty", 32'h0000_0000);

        begin
            logic [10:0] f;
            f = frame_bits(8'h77, 0, 0, 0);
            send_bits(f, 5);
            repeat (TMO + 10) @(negedge clk);
        end
        send_frame(8'hF0, 0, 0, 0);
        check_kd("timeout_f0", 32'h0000_01F0);
        read_pulse(1);
        check_kd("timeout_single", 32'h0000_0000);

        send_frame(8'hAA, 0, 0, 0);
        send_frame(8'hBB, 0, 0, 0);
        check_kd("held_before", 32'h0000_01AA);
        read_pulse(20);
        check_kd("held_after", 32'h0000_01BB);
        read_pulse(1);
        check_kd("held_empty", 32'h0000_0000);

        begin
            logic [10:0] f;
            f = frame_bits(8'hC3, 0, 0, 0);
            send_bits(f, 6);
        end
        do_reset();
        send_frame(8'h5A, 0, 0, 0);
        check_kd("reset_mid_5a", 32'h0000_015A);
        read_pulse(1);
        check_kd("reset_mid_empty", 32'h0000_0000);

        settled = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
